mult_selftest: RTL
==================

# mult_selftest

Parametrised built-in self-test engine for the Karatsuba multiplier, successor to the fixed LED-reporting test harness on the Nexys A7 top level. It generates operand pairs (pseudo-random LFSR stream or a fixed corner-case set) and drives them into a multiplier under test over a valid/ready handshake. Up to DEPTH products can be in flight: expected products are queued, compared in order against returned results, and summarised in pass flags, a saturating error counter and a vector counter that drive on-board LEDs.

## Interface
- W, 32: operand width, legal range 4..32; product width is 2W
- N_VEC, 1024: vectors per random pass, ≥1
- DEPTH, 4: maximum outstanding operations (expected-FIFO depth), power of two ≥2
- ERR_W, 4: error counter width
- SEED, 64'hACE1_0000_0000_0001: LFSR seed, nonzero
- clk  in  1  single clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  level; rising edge in IDLE/DONE launches a pass
- mode  in  2  00 random single pass, 01 corner set, 10 continuous random, 11 treated as 00
- op_valid  out  1  operand pair valid
- op_ready  in  1  multiplier accepts operands
- op_a, op_b  out  W  operands
- res_valid  in  1  multiplier result valid (no backpressure)
- res_p  in  2W  multiplier result
- busy  out  1  state is RUN or DRAIN
- done  out  1  state is DONE
- all_passed  out  1  pass completed with zero errors
- current_passed  out  1  most recent compare matched
- err_count  out  ERR_W  mismatches, saturating at all-ones
- vec_count  out  32  results checked since start

## Operation
- States: IDLE → RUN on start rising edge; RUN → DRAIN when last vector issued (random: N_VEC; corner: 8); RUN → DRAIN in mode 10 when start is low; DRAIN → DONE when FIFO empty; DONE → RUN on next start rising edge.
- Entering RUN: LFSR reloaded with SEED; err_count, vec_count, current_passed cleared; all_passed cleared; FIFO emptied.
- LFSR: 64-bit Fibonacci, taps 64,63,61,60; op_a = state[W-1:0], op_b = state[63:64-W]; advances only on an accepted handshake (op_valid && op_ready).
- Corner set, in order: (0,0), (0,max), (max,0), (max,max), (1,max), (max,1), (msb,msb), (0101…, 1010…); max = all ones, msb = only bit W-1 set.
- Issue rule: op_valid = 1 in RUN while FIFO count < DEPTH; on handshake, a*b (2W bits, unsigned) is pushed to FIFO. No same-cycle push-when-full even if a pop occurs.
- Compare: on res_valid, pop FIFO head, compare to res_p; mismatch increments err_count (saturating), current_passed = match; vec_count increments.
- res_valid with FIFO empty: counted as a mismatch, nothing popped, vec_count unchanged.
- Mode 10: vector counter wraps every N_VEC without leaving RUN; all_passed set at each wrap if err_count = 0, cleared on any error.
- all_passed set on DRAIN → DONE iff err_count = 0; any mismatch clears it immediately.
- mode sampled only at the start edge; changes mid-pass ignored.

## Timing
- Reset values: op_valid 0, op_a/op_b 0, busy 0, done 0, all_passed 0, current_passed 0, err_count 0, vec_count 0; state IDLE.
- op_valid first high in the cycle after the start edge is sampled.
- op_a/op_b/op_valid held stable while op_valid && !op_ready.
- res_valid in cycle t → err_count, current_passed, vec_count updated at t+1.
- Simultaneous push and pop: both happen; count unchanged.
- Reset mid-pass: all state and outputs return to reset values asynchronously; in-flight results after reset release are treated as empty-FIFO mismatches only if state is RUN/DRAIN, else ignored.

## Structure
- Package mult_test_pkg: state enum (IDLE, RUN, DRAIN, DONE), mode encodings, LFSR taps and width, corner-set count.
- Sub-module exp_fifo: DEPTH × 2W synchronous FIFO with count, full, empty; same clock/reset.

## Test plan
- Mode 00, W=8, N_VEC=16, ideal 3-cycle multiplier → done, all_passed=1, err_count=0, vec_count=16.
- Mode 01, result for (max,max) forced wrong → err_count=1, current_passed=0 after that compare, all_passed=0, vec_count=8.
- op_ready held low 10 cycles mid-pass → op_a/op_b stable throughout, no extra FIFO push; DEPTH=4 with results withheld → op_valid drops after 4 issues.
- Multiplier returns every result corrupted, ERR_W=4, N_VEC=32 → err_count saturates at 15.
- Mode 10, start dropped after 40 vectors → DRAIN completes outstanding results, then done=1.
- rst_n pulsed low mid-RUN → all outputs at reset values immediately; spurious res_valid in IDLE leaves err_count 0.

Source files
------------

// File: rtl/mult_test_pkg.sv
// Shared types and constants for the multiplier self-test engine:
// FSM state encoding, mode encodings, LFSR definition, corner-set size.
package mult_test_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [1:0] MODE_RANDOM = 2'b00;
    localparam logic [1:0] MODE_CORNER = 2'b01;
    localparam logic [1:0] MODE_CONT   = 2'b10;
    localparam logic [1:0] MODE_RSVD   = 2'b11;

    localparam int unsigned LFSR_W = 64;
    // Fibonacci taps 64,63,61,60 (1-based) -> bits 63,62,60,59
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 64'hD800_0000_0000_0000;

    localparam int unsigned CORNER_N = 8;

    // One LFSR step: shift left, feedback into bit 0
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
    endfunction

    // Reserved mode behaves as a single random pass
    function automatic logic [1:0] norm_mode(input logic [1:0] m);
        return (m == MODE_RSVD) ? MODE_RANDOM : m;
    endfunction

endpackage

// File: rtl/exp_fifo.sv
// Expected-product FIFO: DEPTH entries of DW bits, registered count/full/empty.
// Ports: clk, rst_n, clr (synchronous flush), push/wdata, pop/rdata (head),
//        count, full, empty. Push when full and pop when empty are ignored.
module exp_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned DW    = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr,
    input  logic                   push,
    input  logic                   pop,
    input  logic [DW-1:0]          wdata,
    output logic [DW-1:0]          rdata,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;
    logic [CW-1:0] count_d;

    // Guarded handshakes and next occupancy
    always_comb begin
        do_push = push && !full;
        do_pop  = pop && !empty;
        count_d = clr ? '0 : (count + CW'(do_push) - CW'(do_pop));
    end

    // Pointers and flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (clr) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (do_push) wr_ptr <= wr_ptr + AW'(1);
                if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_d;
            full  <= (count_d == CW'(DEPTH));
            empty <= (count_d == '0);
        end
    end

    // Storage, no reset needed
    always_ff @(posedge clk) begin
        if (do_push && !clr) mem[wr_ptr] <= wdata;
    end

    assign rdata = mem[rd_ptr];

endmodule

// File: rtl/mult_selftest.sv
// Built-in self-test engine for a W x W multiplier behind a valid/ready port.
// Issues LFSR or corner-case operand pairs, queues expected products and
// checks returned results in order.
// Ports: clk, rst_n, start (rising edge launches), mode; op_valid/op_ready/
//        op_a/op_b to the multiplier; res_valid/res_p from it; status busy,
//        done, all_passed, current_passed, err_count (saturating), vec_count.
module mult_selftest
    import mult_test_pkg::*;
#(
    parameter int unsigned W     = 32,
    parameter int unsigned N_VEC = 1024,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned ERR_W = 4,
    parameter logic [63:0] SEED  = 64'hACE1_0000_0000_0001
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       mode,
    output logic             op_valid,
    input  logic             op_ready,
    output logic [W-1:0]     op_a,
    output logic [W-1:0]     op_b,
    input  logic             res_valid,
    input  logic [2*W-1:0]   res_p,
    output logic             busy,
    output logic             done,
    output logic             all_passed,
    output logic             current_passed,
    output logic [ERR_W-1:0] err_count,
    output logic [31:0]      vec_count
);
    localparam int unsigned PW          = 2 * W;
    localparam int unsigned CW          = $clog2(DEPTH) + 1;
    localparam logic [31:0] RAND_LAST   = 32'(N_VEC - 1);
    localparam logic [31:0] CORNER_LAST = 32'(CORNER_N - 1);
    localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);

    // Corner operand pair {a, b} for index 0..7
    function automatic logic [PW-1:0] corner_pair(input logic [2:0] idx);
        logic [W-1:0] max_v;
        logic [W-1:0] msb_v;
        logic [W-1:0] alt_v;
        logic [W-1:0] one_v;
        max_v = '1;
        msb_v = '0;
        msb_v[W-1] = 1'b1;
        one_v = W'(1);
        alt_v = '0;
        // 0101... read from the MSB down
        for (int unsigned i = 0; i < W; i++) begin
            if (((W - 1 - i) % 2) == 1) alt_v[i] = 1'b1;
        end
        case (idx)
            3'd0:    return {{W{1'b0}}, {W{1'b0}}};
            3'd1:    return {{W{1'b0}}, max_v};
            3'd2:    return {max_v, {W{1'b0}}};
            3'd3:    return {max_v, max_v};
            3'd4:    return {one_v, max_v};
            3'd5:    return {max_v, one_v};
            3'd6:    return {msb_v, msb_v};
            default: return {alt_v, ~alt_v};
        endcase
    endfunction

    function automatic logic [PW-1:0] pick_ops(input logic [1:0] m, input logic [63:0] s,
                                               input logic [2:0] idx);
        if (m == MODE_CORNER) return corner_pair(idx);
        return {s[W-1:0], s[63:64-W]};
    endfunction

    state_t          state_q;
    state_t          state_d;
    logic            start_q;
    logic [1:0]      mode_q;
    logic [63:0]     lfsr_q;
    logic [31:0]     issue_cnt_q;

    logic            launch;
    logic            active;
    logic            cont;
    logic            push;
    logic            pop;
    logic            mismatch;
    logic            last_issue;
    logic            op_valid_d;
    logic [1:0]      mode_sel;
    logic [63:0]     lfsr_adv;
    logic [PW-1:0]   ops_launch;
    logic [PW-1:0]   ops_adv;
    logic [PW-1:0]   prod;
    logic [CW-1:0]   count_d;

    logic [CW-1:0]   fifo_count;
    logic            fifo_full;
    logic            fifo_empty;
    logic [PW-1:0]   fifo_head;

    // Handshake, compare and operand-generation decode
    always_comb begin
        launch     = start && !start_q && (state_q == ST_IDLE || state_q == ST_DONE);
        active     = (state_q == ST_RUN) || (state_q == ST_DRAIN);
        cont       = (mode_q == MODE_CONT);
        push       = op_valid && op_ready && (state_q == ST_RUN) && !fifo_full;
        pop        = active && res_valid && !fifo_empty;
        mismatch   = active && res_valid && (fifo_empty || (fifo_head != res_p));
        last_issue = push && !cont &&
                     (issue_cnt_q == ((mode_q == MODE_CORNER) ? CORNER_LAST : RAND_LAST));
        prod       = PW'(op_a) * PW'(op_b);
        count_d    = fifo_count + CW'(push) - CW'(pop);
        mode_sel   = norm_mode(mode);
        lfsr_adv   = lfsr_next(lfsr_q);
        ops_launch = pick_ops(mode_sel, SEED, 3'd0);
        ops_adv    = pick_ops(mode_q, lfsr_adv, 3'(issue_cnt_q + 32'd1));
    end

    // Next state and next op_valid
    always_comb begin
        state_d    = state_q;
        op_valid_d = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: if (launch) state_d = ST_RUN;
            ST_RUN:   if (last_issue || (cont && !start)) state_d = ST_DRAIN;
            ST_DRAIN: if (fifo_empty) state_d = ST_DONE;
            default:  state_d = ST_IDLE;
        endcase
        // Never offer an operand that would land in a full FIFO
        op_valid_d = (state_d == ST_RUN) && (launch || (count_d < DEPTH_C));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Operand issue side
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_q     <= 1'b0;
            mode_q      <= MODE_RANDOM;
            lfsr_q      <= '0;
            issue_cnt_q <= '0;
            op_valid    <= 1'b0;
            op_a        <= '0;
            op_b        <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            start_q  <= start;
            op_valid <= op_valid_d;
            busy     <= (state_d == ST_RUN) || (state_d == ST_DRAIN);
            done     <= (state_d == ST_DONE);
            if (launch) begin
                mode_q       <= mode_sel;
                lfsr_q       <= SEED;
                issue_cnt_q  <= '0;
                {op_a, op_b} <= ops_launch;
            end else if (push) begin
                lfsr_q       <= lfsr_adv;
                issue_cnt_q  <= issue_cnt_q + 32'd1;
                {op_a, op_b} <= ops_adv;
            end
        end
    end

    // Result checking and status
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count      <= '0;
            vec_count      <= '0;
            current_passed <= 1'b0;
            all_passed     <= 1'b0;
        end else if (launch) begin
            err_count      <= '0;
            vec_count      <= '0;
            current_passed <= 1'b0;
            all_passed     <= 1'b0;
        end else begin
            if (active && res_valid) begin
                current_passed <= !mismatch;
                if (mismatch) begin
                    all_passed <= 1'b0;
                    if (err_count != '1) err_count <= err_count + ERR_W'(1);
                end
                if (pop) begin
                    if (cont && vec_count == RAND_LAST) begin
                        vec_count  <= '0;
                        all_passed <= (err_count == '0) && !mismatch;
                    end else begin
                        vec_count  <= vec_count + 32'd1;
                    end
                end
            end
            if (state_q == ST_DRAIN && state_d == ST_DONE)
                all_passed <= (err_count == '0) && !mismatch;
        end
    end

    exp_fifo #(
        .DEPTH (DEPTH),
        .DW    (PW)
    ) u_exp_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (launch),
        .push  (push),
        .pop   (pop),
        .wdata (prod),
        .rdata (fifo_head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule
